// File: rtl/lspc_pkg.sv
// Shared LSPC definitions: IRQ bit positions, default IPL levels and the level type.
package lspc_pkg;

    typedef logic [2:0] lvl_t;

    localparam int unsigned IRQ_RST = 0;
    localparam int unsigned IRQ_TMR = 1;
    localparam int unsigned IRQ_VBL = 2;
    localparam int unsigned NUM_IRQ = 3;

    localparam lvl_t DEF_VBL_LEVEL   = 3'd1;
    localparam lvl_t DEF_TIMER_LEVEL = 3'd2;
    localparam lvl_t DEF_RESET_LEVEL = 3'd3;

    localparam logic [2:0] IPL_IDLE = 3'b111;

endpackage

// File: rtl/irq_source_latch.sv
// One interrupt source: rising-edge detect, pending and overrun flags, ack/set arbitration.
module irq_source_latch #(
    parameter bit RST_PEND = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic pend,
    output logic ovr
);

    logic req_q;
    logic pend_q, pend_d;
    logic ovr_q, ovr_d;
    logic rise;

    assign rise = req & ~req_q;

    // A new edge always wins over a same-cycle ack, so no event is ever dropped.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (ack) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (rise) begin
            if (pend_q && !ack) begin
                ovr_d = 1'b1;
            end
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= 1'b0;
            pend_q <= RST_PEND;
            ovr_q  <= 1'b0;
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign pend = pend_q;
    assign ovr  = ovr_q;

endmodule

// File: rtl/lspc_irq_ctrl.sv
// LSPC interrupt controller: latches timer/vblank/reset requests and drives registered nIPL.
module lspc_irq_ctrl
    import lspc_pkg::*;
#(
    parameter lvl_t VBL_LEVEL   = DEF_VBL_LEVEL,
    parameter lvl_t TIMER_LEVEL = DEF_TIMER_LEVEL,
    parameter lvl_t RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic       LSPC_6M,
    input  logic       RESETP,
    input  logic       TIMER_IRQ,
    input  logic       VBL_IRQ,
    input  logic       WR_IRQ_ACK,
    input  logic [2:0] M68K_DATA,
    output logic [2:0] nIPL,
    output logic [2:0] IRQ_PENDING,
    output logic [2:0] IRQ_OVERRUN
);

    logic [NUM_IRQ-1:0] ack;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] ovr;
    lvl_t               lvl;
    logic [2:0]         nipl_q;

    assign ack = M68K_DATA & {NUM_IRQ{WR_IRQ_ACK}};

    // The reset IRQ has no request line; it is armed only by RESETP.
    irq_source_latch #(
        .RST_PEND (1'b1)
    ) u_rst_src (
        .clk  (LSPC_6M),
        .rst  (RESETP),
        .req  (1'b0),
        .ack  (ack[IRQ_RST]),
        .pend (pend[IRQ_RST]),
        .ovr  (ovr[IRQ_RST])
    );

    irq_source_latch #(
        .RST_PEND (1'b0)
    ) u_tmr_src (
        .clk  (LSPC_6M),
        .rst  (RESETP),
        .req  (TIMER_IRQ),
        .ack  (ack[IRQ_TMR]),
        .pend (pend[IRQ_TMR]),
        .ovr  (ovr[IRQ_TMR])
    );

    irq_source_latch #(
        .RST_PEND (1'b0)
    ) u_vbl_src (
        .clk  (LSPC_6M),
        .rst  (RESETP),
        .req  (VBL_IRQ),
        .ack  (ack[IRQ_VBL]),
        .pend (pend[IRQ_VBL]),
        .ovr  (ovr[IRQ_VBL])
    );

    // A source configured at level 0 keeps its pending bit but yields to lower priorities.
    always_comb begin
        lvl = 3'd0;
        if (pend[IRQ_RST] && (RESET_LEVEL != 3'd0)) begin
            lvl = RESET_LEVEL;
        end else if (pend[IRQ_TMR] && (TIMER_LEVEL != 3'd0)) begin
            lvl = TIMER_LEVEL;
        end else if (pend[IRQ_VBL] && (VBL_LEVEL != 3'd0)) begin
            lvl = VBL_LEVEL;
        end
    end

    always_ff @(posedge LSPC_6M) begin
        if (RESETP) begin
            nipl_q <= IPL_IDLE;
        end else begin
            nipl_q <= ~lvl;
        end
    end

    assign nIPL        = nipl_q;
    assign IRQ_PENDING = pend;
    assign IRQ_OVERRUN = ovr;

endmodule
